gpr_multiport: RTL and testbench



---
 rtl/gpr_multiport_pkg.sv | 13 +
 rtl/gpr_scoreboard.sv | 56 +++++
 rtl/gpr_multiport.sv | 130 +++++++++++++
 tb/tb_gpr_multiport.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_multiport_pkg.sv
// Shared types and defaults for the multiport register file.
// Holds the FSM state encoding and default geometry.
package gpr_multiport_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-result scoreboard: one bit per entry, set by issue, cleared by writeback.
// A set and a writeback-clear of the same entry in one cycle leaves the bit set.
module gpr_scoreboard
   import gpr_multiport_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr0_en,
   input  logic [ADDR_W-1:0] clr0_addr,
   input  logic              clr1_en,
   input  logic [ADDR_W-1:0] clr1_addr,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic              pending_1,
   output logic              pending_2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] pend_reg;
   logic [DEPTH-1:0] pend_next;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
         if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign pend_next[gi] = 1'b0;
         end else begin : g_live
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_addr == ADDR_W'(gi));
            assign clr_hit = (clr0_en && (clr0_addr == ADDR_W'(gi))) ||
                             (clr1_en && (clr1_addr == ADDR_W'(gi)));
            assign pend_next[gi] = set_hit ? 1'b1 :
                                   clr_hit ? 1'b0 : pend_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   // Registered view only; same-cycle set/clear is visible from the next cycle.
   assign pending_1 = pend_reg[rd_addr_1];
   assign pending_2 = pend_reg[rd_addr_2];

endmodule

// File: rtl/gpr_multiport.sv
// Two-write / two-read register file with write forwarding, an optional
// hardwired zero entry, a post-reset clear sweep and a pending scoreboard.
module gpr_multiport
   import gpr_multiport_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic [DATA_W-1:0] rd_data_1,
   output logic [DATA_W-1:0] rd_data_2,
   input  logic              sb_set_en,
   input  logic [ADDR_W-1:0] sb_set_addr,
   output logic              pending_1,
   output logic              pending_2
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

   gpr_state_e        state_reg;
   gpr_state_e        state_next;
   logic [ADDR_W:0]   cnt_reg;
   logic              ready;
   logic              wr0_ok;
   logic              wr1_ok;
   logic              sb_pend_1;
   logic              sb_pend_2;
   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [ADDR_W-1:0] rd_addr_arr [2];
   logic [DATA_W-1:0] rd_data_arr [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_INIT;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_INIT) begin
            cnt_reg <= cnt_reg + (ADDR_W + 1)'(1);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT:  if (cnt_reg == LAST_IDX) state_next = ST_READY;
         ST_READY: state_next = ST_READY;
         default:  state_next = ST_INIT;
      endcase
   end

   always_comb begin
      init_busy = (state_reg == ST_INIT);
      ready     = (state_reg == ST_READY);
   end

   // Writes to the hardwired zero entry are dropped before they reach storage or scoreboard.
   assign wr0_ok = ready && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
   assign wr1_ok = ready && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

   // Storage is never reset; the INIT sweep is the only thing that zeroes it.
   always_ff @(posedge clk) begin
      if (init_busy) begin
         mem_reg[cnt_reg[ADDR_W-1:0]] <= '0;
      end else begin
         if (wr0_ok) mem_reg[wr0_addr] <= wr0_data;
         if (wr1_ok) mem_reg[wr1_addr] <= wr1_data;
      end
   end

   assign rd_addr_arr[0] = rd_addr_1;
   assign rd_addr_arr[1] = rd_addr_2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic [DATA_W-1:0] rd_val;
         always_comb begin
            rd_val = '0;
            if (ready && !((ZERO_REG != 0) && (rd_addr_arr[gi] == '0))) begin
               if (wr1_ok && (wr1_addr == rd_addr_arr[gi])) begin
                  rd_val = wr1_data;
               end else if (wr0_ok && (wr0_addr == rd_addr_arr[gi])) begin
                  rd_val = wr0_data;
               end else begin
                  rd_val = mem_reg[rd_addr_arr[gi]];
               end
            end
         end
         assign rd_data_arr[gi] = rd_val;
      end
   endgenerate

   assign rd_data_1 = rd_data_arr[0];
   assign rd_data_2 = rd_data_arr[1];

   gpr_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (sb_set_en && ready),
      .set_addr  (sb_set_addr),
      .clr0_en   (wr0_ok),
      .clr0_addr (wr0_addr),
      .clr1_en   (wr1_ok),
      .clr1_addr (wr1_addr),
      .rd_addr_1 (rd_addr_1),
      .rd_addr_2 (rd_addr_2),
      .pending_1 (sb_pend_1),
      .pending_2 (sb_pend_2)
   );

   assign pending_1 = ready && sb_pend_1;
   assign pending_2 = ready && sb_pend_2;

endmodule

// File: tb/tb_gpr_multiport.sv
// Directed bench for gpr_multiport: a cycles-since-reset reference model is
// checked every cycle, plus literal expectations queued by the stimulus.
module tb_gpr_multiport;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              init_busy;
   logic              wr0_en = 1'b0, wr1_en = 1'b0;
   logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
   logic [DATA_W-1:0] wr0_data = '0, wr1_data = '0;
   logic [ADDR_W-1:0] rd_addr_1 = '0, rd_addr_2 = '0;
   logic [DATA_W-1:0] rd_data_1, rd_data_2;
   logic              sb_set_en = 1'b0;
   logic [ADDR_W-1:0] sb_set_addr = '0;
   logic              pending_1, pending_2;

   gpr_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .init_busy   (init_busy),
      .wr0_en      (wr0_en),
      .wr0_addr    (wr0_addr),
      .wr0_data    (wr0_data),
      .wr1_en      (wr1_en),
      .wr1_addr    (wr1_addr),
      .wr1_data    (wr1_data),
      .rd_addr_1   (rd_addr_1),
      .rd_addr_2   (rd_addr_2),
      .rd_data_1   (rd_data_1),
      .rd_data_2   (rd_data_2),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .pending_1   (pending_1),
      .pending_2   (pending_2)
   );

   always #5 clk = ~clk;

   // Reference model: the file is busy for the first DEPTH clocks after reset.
   int          cycles_m;
   logic [15:0] mem_m  [DEPTH];
   logic        pend_m [DEPTH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cycles_m <= 0;
         for (int i = 0; i < DEPTH; i++) pend_m[i] <= 1'b0;
      end else if (cycles_m < DEPTH) begin
         mem_m[cycles_m] <= 16'h0000;
         cycles_m <= cycles_m + 1;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr0_en && int'(wr0_addr) == i) mem_m[i] <= wr0_data;
            if (wr1_en && int'(wr1_addr) == i) mem_m[i] <= wr1_data;
            if (sb_set_en && int'(sb_set_addr) == i)
               pend_m[i] <= 1'b1;
            else if ((wr0_en && int'(wr0_addr) == i) || (wr1_en && int'(wr1_addr) == i))
               pend_m[i] <= 1'b0;
         end
      end
   end

   function automatic logic [15:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (cycles_m < DEPTH || a == 0) return 16'h0000;
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
      return mem_m[a];
   endfunction

   function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
      if (cycles_m < DEPTH || a == 0) return 1'b0;
      return pend_m[a];
   endfunction

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } lit_t;

   lit_t lit_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] pick(input int sel);
      case (sel)
         0:       return {15'd0, init_busy};
         1:       return rd_data_1;
         2:       return rd_data_2;
         3:       return {15'd0, pending_1};
         default: return {15'd0, pending_2};
      endcase
   endfunction

   // Compare process: model vs DUT every cycle, then any queued literal checks.
   always @(negedge clk) begin
      check("model_init_busy", {15'd0, init_busy}, {15'd0, cycles_m < DEPTH});
      check("model_rd_data_1", rd_data_1, exp_rd(rd_addr_1));
      check("model_rd_data_2", rd_data_2, exp_rd(rd_addr_2));
      check("model_pending_1", {15'd0, pending_1}, {15'd0, exp_pend(rd_addr_1)});
      check("model_pending_2", {15'd0, pending_2}, {15'd0, exp_pend(rd_addr_2)});
      while (lit_q.size() > 0) begin
         lit_t l;
         l = lit_q.pop_front();
         $display("[%0t] txn %s: got %h expect %h", $time, l.name, pick(l.sel), l.exp);
         check(l.name, pick(l.sel), l.exp);
      end
   end

   task automatic push(input string n, input int s, input logic [15:0] e);
      lit_t l;
      l.name = n;
      l.sel  = s;
      l.exp  = e;
      lit_q.push_back(l);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      wr0_en = 1'b0;
      wr1_en = 1'b0;
      sb_set_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push("init_busy_high", 0, 16'h0001);
         cyc();
      end
      push("init_busy_low", 0, 16'h0000);
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr_1 = ADDR_W'(a);
         push("cleared_entry", 1, 16'h0000);
         cyc();
      end

      // Same-address dual write: port 1 wins.
      wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'h1234;
      wr1_en = 1'b1; wr1_addr = 3'd3; wr1_data = 16'hBEEF;
      cyc();
      idle();
      rd_addr_1 = 3'd3;
      push("dual_write_port1_wins", 1, 16'hBEEF);
      cyc();

      // Forwarding then stored value.
      wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 16'h00AA;
      rd_addr_2 = 3'd5;
      push("forward_rd2", 2, 16'h00AA);
      cyc();
      idle();
      push("stored_rd2", 2, 16'h00AA);
      cyc();

      // Zero entry ignores writes, even forwarded.
      rd_addr_1 = 3'd0;
      wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 16'hFFFF;
      push("zero_reg_before", 1, 16'h0000);
      cyc();
      idle();
      push("zero_reg_after", 1, 16'h0000);
      cyc();

      // Scoreboard set / set-beats-clear / clear.
      rd_addr_1 = 3'd2;
      sb_set_en = 1'b1; sb_set_addr = 3'd2;
      push("pend_not_forwarded", 3, 16'h0000);
      cyc();
      idle();
      push("pend_set", 3, 16'h0001);
      sb_set_en = 1'b1; sb_set_addr = 3'd2;
      wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'h0007;
      cyc();
      idle();
      push("pend_set_wins", 3, 16'h0001);
      wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h0009;
      cyc();
      idle();
      push("pend_cleared", 3, 16'h0000);
      push("wr1_data_stored", 1, 16'h0009);
      rd_addr_2 = 3'd0;
      sb_set_en = 1'b1; sb_set_addr = 3'd0;
      cyc();
      idle();
      push("pend_zero_reg", 4, 16'h0000);
      sb_set_en = 1'b1; sb_set_addr = 3'd4;
      cyc();
      idle();
      rd_addr_2 = 3'd4;
      push("pend4_set", 4, 16'h0001);
      cyc();

      // Reset, then a second reset after four INIT cycles.
      rst = 1'b1;
      push("rst_busy", 0, 16'h0001);
      push("rst_pend_clear", 4, 16'h0000);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push("init1_busy", 0, 16'h0001);
         cyc();
      end
      rst = 1'b1;
      push("midinit_rst_busy", 0, 16'h0001);
      cyc();
      rst = 1'b0;
      rd_addr_1 = 3'd6;
      rd_addr_2 = 3'd7;
      wr0_en = 1'b1; wr0_addr = 3'd6; wr0_data = 16'h5555;
      wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 16'h7777;
      sb_set_en = 1'b1; sb_set_addr = 3'd6;
      for (int i = 0; i < DEPTH; i++) begin
         push("init2_busy", 0, 16'h0001);
         push("init2_rd_zero", 1, 16'h0000);
         cyc();
      end
      idle();
      push("init2_done", 0, 16'h0000);
      push("init_write_ignored", 1, 16'h0000);
      push("init_write1_ignored", 2, 16'h0000);
      push("init_set_ignored", 3, 16'h0000);
      cyc();
      rd_addr_1 = 3'd3;
      rd_addr_2 = 3'd4;
      push("reinit_cleared", 1, 16'h0000);
      push("pend4_after_reset", 4, 16'h0000);
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
